// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample types and I2S framing constants
package audio_pkg;

  typedef logic signed [23:0] sample24_t;

  typedef struct packed {
    sample24_t l;
    sample24_t r;
  } stereo24_t;

  localparam int I2S_SLOTS_PER_CH = 32;
  localparam int I2S_DATA_BITS    = 24;

  // IDLE: lines parked low, counters cleared; RUN: frames being serialised
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous FIFO with occupancy level, show-ahead head output
module sample_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage write; caller guarantees push is only asserted when space exists (or a pop frees it)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks net push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - FIFO-buffered Philips I2S transmitter for 24-bit stereo samples
module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int UNDER_W    = 16,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sample,
  input  logic [23:0]        left_in,
  input  logic [23:0]        right_in,
  output logic               bclk,
  output logic               lrclk,
  output logic               sdata,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               overflow,
  output logic [UNDER_W-1:0] underrun_cnt
);

  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int SLOT_W = $clog2(2 * I2S_SLOTS_PER_CH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = '1;

  tx_state_t          state_q;
  tx_state_t          state_d;
  logic               do_load;
  logic               do_stop;
  logic               running;
  logic [DIV_W-1:0]   div_cnt;
  logic               tc;
  logic               fall;
  logic               wrap;
  logic [SLOT_W-1:0]  slot;
  logic [SLOT_W-1:0]  slot_nxt;
  logic [SLOT_W-2:0]  k_nxt;
  logic               data_slot;
  sample24_t          sh_l;
  sample24_t          sh_r;
  stereo24_t          last_pair;
  stereo24_t          fifo_dout;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;

  assign running   = (state_q == ST_RUN);
  assign tc        = (div_cnt == DIV_LAST);
  assign fall      = running && tc && bclk;
  assign wrap      = fall && (slot == SLOT_LAST);
  assign slot_nxt  = slot + 1'b1;
  assign k_nxt     = slot_nxt[SLOT_W-2:0];
  // Half-slot 0 is the I2S one-bit delay; data occupies half-slots 1..24
  assign data_slot = (k_nxt != '0) && (k_nxt <= (SLOT_W-1)'(I2S_DATA_BITS));

  // A full FIFO can still take a strobe when the frame load pops in the same cycle
  assign fifo_pop  = do_load && !fifo_empty;
  assign fifo_push = sample && (!fifo_full || fifo_pop);

  sample_fifo #(
    .WIDTH($bits(stereo24_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({left_in, right_in}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Run/idle state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame boundary decisions: load on enable or wrap, park at the wrap when disabled
  always_comb begin
    state_d = state_q;
    do_load = 1'b0;
    do_stop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
          do_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (wrap) begin
          if (en) begin
            do_load = 1'b1;
          end else begin
            do_stop = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky overflow, saturating underrun count and the repeat-on-empty pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow     <= 1'b0;
      underrun_cnt <= '0;
      last_pair    <= '0;
    end else begin
      if (sample && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end
      if (fifo_pop) begin
        last_pair <= fifo_dout;
      end else if (do_load && (underrun_cnt != '1)) begin
        underrun_cnt <= underrun_cnt + 1'b1;
      end
    end
  end

  // Bit clock divider and slot counter; everything held at zero while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      slot    <= '0;
      lrclk   <= 1'b0;
    end else if (!running || do_stop) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      slot    <= '0;
      lrclk   <= 1'b0;
    end else begin
      if (tc) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall) begin
        slot  <= slot_nxt;
        lrclk <= slot_nxt[SLOT_W-1];
      end
    end
  end

  // Channel shift registers and serial data, updated on fall events so the codec samples on rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_l  <= '0;
      sh_r  <= '0;
      sdata <= 1'b0;
    end else begin
      if (do_load) begin
        sh_l <= fifo_pop ? fifo_dout.l : last_pair.l;
        sh_r <= fifo_pop ? fifo_dout.r : last_pair.r;
      end
      if (!running || do_stop) begin
        sdata <= 1'b0;
      end else if (fall) begin
        if (data_slot) begin
          if (slot_nxt[SLOT_W-1]) begin
            sdata <= sh_r[23];
            sh_r  <= {sh_r[22:0], 1'b0};
          end else begin
            sdata <= sh_l[23];
            sh_l  <= {sh_l[22:0], 1'b0};
          end
        end else begin
          sdata <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - self-checking bench for the I2S transmitter
module tb_i2s_audio_tx;

  localparam int BCLK_DIV   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int UNDER_W    = 16;
  localparam int FRAME_CLKS = 2 * BCLK_DIV * 64;

  logic               clk;
  logic               rst;
  logic               en;
  logic               sample;
  logic [23:0]        left_in;
  logic [23:0]        right_in;
  logic               bclk;
  logic               lrclk;
  logic               sdata;
  logic [2:0]         fifo_level;
  logic               overflow;
  logic [UNDER_W-1:0] underrun_cnt;

  logic               sat_en;
  logic               sat_sample;
  logic               sat_bclk;
  logic               sat_lrclk;
  logic               sat_sdata;
  logic [1:0]         sat_level;
  logic               sat_ovf;
  logic [1:0]         sat_under;

  int checks   = 0;
  int failures = 0;
  int frame_cnt = 0;

  logic [47:0] exp_q[$];

  i2s_audio_tx #(
    .BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .UNDER_W(UNDER_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sample(sample),
    .left_in(left_in), .right_in(right_in),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .fifo_level(fifo_level), .overflow(overflow), .underrun_cnt(underrun_cnt)
  );

  i2s_audio_tx #(
    .BCLK_DIV(2), .FIFO_DEPTH(2), .UNDER_W(2)
  ) u_sat (
    .clk(clk), .rst(rst), .en(sat_en), .sample(sat_sample),
    .left_in(24'h0), .right_in(24'h0),
    .bclk(sat_bclk), .lrclk(sat_lrclk), .sdata(sat_sdata),
    .fifo_level(sat_level), .overflow(sat_ovf), .underrun_cnt(sat_under)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // I2S receiver model: samples on bclk rise, frames end at right-channel half-slot 31
  int          pos = -1;
  logic        prev_lr = 1'b0;
  logic        bclk_q = 1'b0;
  logic        pad_bad = 1'b0;
  logic [23:0] cur_l = '0;
  logic [23:0] cur_r = '0;
  logic [47:0] exp_frame;

  always @(negedge clk) begin
    if (rst) begin
      pos     = -1;
      prev_lr = 1'b0;
      bclk_q  = 1'b0;
      pad_bad = 1'b0;
    end else begin
      if (bclk && !bclk_q) begin
        if (lrclk != prev_lr) pos = 0;
        else pos = pos + 1;
        prev_lr = lrclk;
        if (pos >= 1 && pos <= 24) begin
          if (lrclk) cur_r = {cur_r[22:0], sdata};
          else       cur_l = {cur_l[22:0], sdata};
        end else if (sdata) begin
          pad_bad = 1'b1;
        end
        if (lrclk && pos == 31) begin
          frame_cnt++;
          if (exp_q.size() == 0) begin
            check("frame_unexpected", {cur_l, cur_r}, 48'h0);
            checks++;
            failures++;
            $display("FAIL frame_extra actual=%0h required=none", {cur_l, cur_r});
          end else begin
            exp_frame = exp_q.pop_front();
            check("frame_data", {cur_l, cur_r}, exp_frame);
          end
          check("frame_pad_zero", pad_bad, 1'b0);
          pad_bad = 1'b0;
        end
      end
      bclk_q = bclk;
    end
  end

  task automatic wait_frames(input int n);
    int target = frame_cnt + n;
    int budget = n * (FRAME_CLKS + 64) + 64;
    while (frame_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (frame_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL wait_frames timeout actual=%0d required=%0d", frame_cnt, target);
    end
  endtask

  task automatic wait_rises(input int n);
    int   seen   = 0;
    int   budget = n * 2 * BCLK_DIV + 50;
    logic p      = bclk;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (bclk && !p) seen++;
      p = bclk;
    end
    if (seen < n) begin
      checks++;
      failures++;
      $display("FAIL wait_rises timeout actual=%0d required=%0d", seen, n);
    end
  endtask

  task automatic do_reset(input logic en_val);
    @(negedge clk);
    rst    = 1'b1;
    en     = en_val;
    sample = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
    @(negedge clk);
    sample   = 1'b1;
    left_in  = l;
    right_in = r;
    @(negedge clk);
    sample = 1'b0;
  endtask

  task automatic check_idle(input string name, input int cycles);
    logic bad = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bclk || lrclk || sdata) bad = 1'b1;
    end
    check(name, bad, 1'b0);
  endtask

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [2:0]  lvl;
    logic        ovf;
  } push_vec_t;

  push_vec_t tbl [5];
  int        per;
  logic      p;

  initial begin
    tbl[0] = '{l: 24'h123456, r: 24'hABCDEF, lvl: 3'd1, ovf: 1'b0};
    tbl[1] = '{l: 24'hFFFFFF, r: 24'h000001, lvl: 3'd2, ovf: 1'b0};
    tbl[2] = '{l: 24'h555555, r: 24'hAAAAAA, lvl: 3'd3, ovf: 1'b0};
    tbl[3] = '{l: 24'h800000, r: 24'h7FFFFF, lvl: 3'd4, ovf: 1'b0};
    tbl[4] = '{l: 24'hDEAD01, r: 24'hBEEF02, lvl: 3'd4, ovf: 1'b1};

    rst = 1'b1; en = 1'b0; sample = 1'b0; left_in = '0; right_in = '0;
    sat_en = 1'b0; sat_sample = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bclk", bclk, 1'b0);
    check("rst_lrclk", lrclk, 1'b0);
    check("rst_sdata", sdata, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_underrun", underrun_cnt, 16'd0);

    // Starved: zero frames, one underrun per frame; small instance saturates
    rst = 1'b0; en = 1'b1; sat_en = 1'b1;
    repeat (3) exp_q.push_back(48'h0);
    wait_frames(3);
    check("starve_underrun", underrun_cnt, 16'd3);
    check("starve_overflow", overflow, 1'b0);
    check("sat_underrun_hold", sat_under, 2'b11);
    sat_en = 1'b0;

    // Single push after enable lands in frame 2, then repeats while starved
    do_reset(1'b1);
    push_pair(24'h800001, 24'h7FFFFE);
    exp_q.push_back(48'h0);
    repeat (3) exp_q.push_back({24'h800001, 24'h7FFFFE});
    wait_rises(1);
    per = 0; p = bclk;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      per++;
      if (bclk && !p) break;
      p = bclk;
    end
    check("bclk_period", per, 2 * BCLK_DIV);
    wait_frames(4);
    check("repeat_underrun", underrun_cnt, 16'd3);
    check("repeat_level", fifo_level, 3'd0);

    // Table: fill while idle, fifth push overflows and is dropped
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      push_pair(tbl[i].l, tbl[i].r);
      check($sformatf("tbl_level_%0d", i), fifo_level, tbl[i].lvl);
      check($sformatf("tbl_ovf_%0d", i), overflow, tbl[i].ovf);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back({tbl[i].l, tbl[i].r});
    @(negedge clk);
    en = 1'b1;
    wait_frames(4);
    en = 1'b0;
    repeat (2 * BCLK_DIV + 4) @(negedge clk);
    check_idle("tbl_stop_idle", 40);
    check("tbl_ovf_sticky", overflow, 1'b1);
    check("tbl_level_empty", fifo_level, 3'd0);
    check("tbl_no_underrun", underrun_cnt, 16'd0);

    // Full FIFO, push in the same cycle as the load pop
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) push_pair(24'h100000 + 24'(i), 24'h200000 + 24'(i));
    check("full_level", fifo_level, 3'd4);
    @(negedge clk);
    en = 1'b1; sample = 1'b1; left_in = 24'hC0FFEE; right_in = 24'h0BADF0;
    @(negedge clk);
    sample = 1'b0;
    check("poppush_level", fifo_level, 3'd4);
    check("poppush_overflow", overflow, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back({24'h100000 + 24'(i), 24'h200000 + 24'(i)});
    exp_q.push_back({24'hC0FFEE, 24'h0BADF0});
    wait_frames(5);
    en = 1'b0;
    check("poppush_underrun", underrun_cnt, 16'd0);

    // Disable mid-frame, push while idle, resume with the FIFO head
    do_reset(1'b1);
    push_pair(24'h0F0F0F, 24'hF0F0F0);
    exp_q.push_back(48'h0);
    exp_q.push_back({24'h0F0F0F, 24'hF0F0F0});
    exp_q.push_back({24'h0F0F0F, 24'hF0F0F0});
    exp_q.push_back({24'h135790, 24'h2468AC});
    wait_frames(2);
    wait_rises(11);
    en = 1'b0;
    wait_frames(1);
    repeat (2 * BCLK_DIV + 4) @(negedge clk);
    check_idle("en_off_idle", 64);
    push_pair(24'h135790, 24'h2468AC);
    check("en_off_push_level", fifo_level, 3'd1);
    check("en_off_underrun", underrun_cnt, 16'd2);
    en = 1'b1;
    wait_frames(1);

    // Reset mid-frame around slot 40; next frame restarts with zero data
    begin
      int budget = FRAME_CLKS;
      while (!lrclk && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      check("reach_right_channel", lrclk, 1'b1);
    end
    wait_rises(8);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bclk", bclk, 1'b0);
    check("midrst_lrclk", lrclk, 1'b0);
    check("midrst_sdata", sdata, 1'b0);
    check("midrst_level", fifo_level, 3'd0);
    check("midrst_underrun", underrun_cnt, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(48'h0);
    wait_frames(1);
    check("midrst_after_underrun", underrun_cnt, 16'd1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
